// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

  // Line level while nothing is being sent (mark).
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Encoded word length as carried by the line-control config.
  typedef enum logic [1:0] {
    WLEN_5 = 2'd0,
    WLEN_6 = 2'd1,
    WLEN_7 = 2'd2,
    WLEN_8 = 2'd3
  } wlen_e;

  // Serializer phases; everything except TX_IDLE counts as busy.
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  // Parity bit for a word of the given length. Stick parity ignores the
  // data and sends the inverse of eps; otherwise even parity (eps=1) is the
  // XOR of the data bits and odd parity is its inverse.
  function automatic logic uart_parity(input logic [7:0] data, input wlen_e wlen,
                                       input logic eps, input logic sps);
    logic x;
    x = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < 5 + int'(wlen)) x = x ^ data[i];
    end
    if (sps) return !eps;
    return eps ? x : !x;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; head word is visible on pop_data.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // Flags come straight off the registered count so they move with it.
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array; no reset needed since reads are gated by the count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: TX FIFO, frame serializer with per-frame latched line
// control, baud down-counter, CTS gating, break and level TX interrupt.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                        PCLK,
  input  logic                        PRESET,
  input  logic                        wr_valid,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        wr_ready,
  input  logic                        cfg_en,
  input  logic [1:0]                  cfg_wlen,
  input  logic                        cfg_pen,
  input  logic                        cfg_eps,
  input  logic                        cfg_sps,
  input  logic                        cfg_stp2,
  input  logic                        cfg_brk,
  input  logic [DIV_W-1:0]            cfg_divisor,
  input  logic [$clog2(FIFO_DEPTH):0] cfg_txlvl,
  input  logic                        cfg_ctsen,
  input  logic                        nUARTCTS,
  output logic                        UARTTXD,
  output logic                        tx_busy,
  output logic                        tx_fifo_full,
  output logic                        tx_fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0] tx_fifo_count,
  output logic                        UARTTXINTR
);

  logic [DATA_W-1:0] fifo_head;
  logic              fifo_pop;

  uart_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (PCLK),
    .rst       (PRESET),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (tx_fifo_count),
    .full      (tx_fifo_full),
    .empty     (tx_fifo_empty)
  );

  assign wr_ready = !tx_fifo_full;

  tx_state_e         state;
  logic [DIV_W-1:0]  baud_cnt;   // cycles left in the current bit, minus one
  logic [DIV_W-1:0]  div_q;      // bit period latched at frame start
  logic [2:0]        bit_cnt;    // data bit index, or second-stop flag in STOP
  logic [DATA_W-1:0] shreg;
  wlen_e             wlen_q;
  logic              pen_q, stp2_q, par_q;

  logic [DIV_W-1:0]  div_eff;
  logic              start_ok, bit_done, last_data, last_stop, launch, line_lvl;

  assign tx_busy = (state != TX_IDLE);

  // Start gating, bit boundaries and the level the serializer wants on the line.
  always_comb begin
    div_eff   = (cfg_divisor == '0) ? DIV_W'(1) : cfg_divisor;
    start_ok  = cfg_en && !tx_fifo_empty && (!cfg_ctsen || !nUARTCTS);
    bit_done  = (baud_cnt == '0);
    // Last data bit index is wlen+4, i.e. {1, wlen} in three bits.
    last_data = (bit_cnt == {1'b1, wlen_q});
    last_stop = (state == TX_STOP) && bit_done && (!stp2_q || bit_cnt[0]);
    // A new frame can start from idle or directly off the final stop bit.
    launch    = start_ok && ((state == TX_IDLE) || last_stop);
    fifo_pop  = launch;
    line_lvl  = UART_IDLE_LEVEL;
    case (state)
      TX_START:  line_lvl = 1'b0;
      TX_DATA:   line_lvl = shreg[0];
      TX_PARITY: line_lvl = par_q;
      TX_STOP:   line_lvl = 1'b1;
      default:   line_lvl = UART_IDLE_LEVEL;
    endcase
  end

  // Frame serializer: latches line control on launch, walks the bit phases.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      div_q    <= DIV_W'(1);
      bit_cnt  <= '0;
      shreg    <= '0;
      wlen_q   <= WLEN_8;
      pen_q    <= 1'b0;
      stp2_q   <= 1'b0;
      par_q    <= 1'b0;
      UARTTXD  <= UART_IDLE_LEVEL;
    end else begin
      // Line follows the state one cycle later; break overrides it.
      UARTTXD <= cfg_brk ? 1'b0 : line_lvl;
      if (launch) begin
        state    <= TX_START;
        shreg    <= fifo_head;
        div_q    <= div_eff;
        baud_cnt <= div_eff - DIV_W'(1);
        bit_cnt  <= '0;
        wlen_q   <= wlen_e'(cfg_wlen);
        pen_q    <= cfg_pen;
        stp2_q   <= cfg_stp2;
        par_q    <= uart_parity(8'(fifo_head), wlen_e'(cfg_wlen), cfg_eps, cfg_sps);
      end else if (state != TX_IDLE) begin
        if (!bit_done) begin
          baud_cnt <= baud_cnt - DIV_W'(1);
        end else begin
          baud_cnt <= div_q - DIV_W'(1);
          case (state)
            TX_START: begin
              state   <= TX_DATA;
              bit_cnt <= '0;
            end
            TX_DATA: begin
              shreg <= shreg >> 1;
              if (last_data) begin
                state   <= pen_q ? TX_PARITY : TX_STOP;
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
            TX_PARITY: begin
              state   <= TX_STOP;
              bit_cnt <= '0;
            end
            TX_STOP: begin
              if (last_stop) state <= TX_IDLE;
              else           bit_cnt <= 3'd1;
            end
            default: state <= TX_IDLE;
          endcase
        end
      end
    end
  end

  // Level interrupt: FIFO at or below threshold while enabled.
  always_ff @(posedge PCLK) begin
    if (PRESET) UARTTXINTR <= 1'b0;
    else        UARTTXINTR <= cfg_en && (tx_fifo_count <= cfg_txlvl);
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: directed scenarios with random data, frames
// compared cycle by cycle against bit lists built from the frame rules.
module tb_uart_tx_engine;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        cfg_en, cfg_pen, cfg_eps, cfg_sps, cfg_stp2, cfg_brk, cfg_ctsen;
  logic [1:0]  cfg_wlen;
  logic [15:0] cfg_divisor;
  logic [4:0]  cfg_txlvl;
  logic        nUARTCTS;
  logic        UARTTXD, tx_busy, tx_fifo_full, tx_fifo_empty, UARTTXINTR;
  logic [4:0]  tx_fifo_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  uart_tx_engine #(.DATA_W(8), .FIFO_DEPTH(16), .DIV_W(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .cfg_en(cfg_en), .cfg_wlen(cfg_wlen), .cfg_pen(cfg_pen),
    .cfg_eps(cfg_eps), .cfg_sps(cfg_sps), .cfg_stp2(cfg_stp2), .cfg_brk(cfg_brk),
    .cfg_divisor(cfg_divisor), .cfg_txlvl(cfg_txlvl), .cfg_ctsen(cfg_ctsen),
    .nUARTCTS(nUARTCTS), .UARTTXD(UARTTXD), .tx_busy(tx_busy),
    .tx_fifo_full(tx_fifo_full), .tx_fifo_empty(tx_fifo_empty),
    .tx_fifo_count(tx_fifo_count), .UARTTXINTR(UARTTXINTR)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One write cycle; called and returns on a falling edge.
  task automatic push(input logic [7:0] d, input bit keep);
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge PCLK);
    wr_valid = 1'b0;
    if (keep) exp_q.push_back(d);
  endtask

  // Expected frame = start 0, wlen LSB-first data bits, optional parity,
  // 1 or 2 stop bits, each held max(divisor,1) cycles.
  task automatic check_frame(input bit wait_start, input bit scramble, input string tag);
    logic [7:0]  d;
    logic        bits[$];
    logic        p;
    int          nb, dv, ones, n;
    logic [1:0]  s_wlen;
    logic [15:0] s_div;
    logic        s_pen;
    d    = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    nb   = 5 + int'(cfg_wlen);
    dv   = (cfg_divisor == 0) ? 1 : int'(cfg_divisor);
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (cfg_pen) begin
      if (cfg_sps) p = !cfg_eps;
      else         p = ((ones % 2) == 1) ^ !cfg_eps;
      bits.push_back(p);
    end
    bits.push_back(1'b1);
    if (cfg_stp2) bits.push_back(1'b1);
    s_wlen = cfg_wlen; s_div = cfg_divisor; s_pen = cfg_pen;
    @(negedge PCLK);
    if (wait_start) begin
      n = 0;
      while (UARTTXD !== 1'b0 && n < 4000) begin
        @(negedge PCLK);
        n++;
      end
    end
    // Changing line control mid-frame must not disturb this frame.
    if (scramble) begin
      cfg_wlen = ~s_wlen; cfg_divisor = s_div + 16'd3; cfg_pen = !s_pen;
    end
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c < dv; c++) begin
        if (b != 0 || c != 0) @(negedge PCLK);
        chk($sformatf("%s_d%02h_bit%0d", tag, d, b), 32'(UARTTXD), 32'(bits[b]));
      end
    end
    if (scramble) begin
      cfg_wlen = s_wlen; cfg_divisor = s_div; cfg_pen = s_pen;
    end
  endtask

  initial begin
    logic [7:0] r;
    int bc, mc, prev, n;
    logic eps_t[4];
    logic sps_t[4];
    eps_t = '{1'b1, 1'b0, 1'b1, 1'b0};
    sps_t = '{1'b0, 1'b0, 1'b1, 1'b1};

    PRESET = 1'b1; wr_valid = 1'b0; wr_data = 8'h00;
    cfg_en = 1'b0; cfg_wlen = 2'd3; cfg_pen = 1'b0; cfg_eps = 1'b0; cfg_sps = 1'b0;
    cfg_stp2 = 1'b0; cfg_brk = 1'b0; cfg_divisor = 16'd4; cfg_txlvl = 5'd0;
    cfg_ctsen = 1'b0; nUARTCTS = 1'b0;
    repeat (2) @(negedge PCLK);
    chk("rst_line", 32'(UARTTXD), 1);
    chk("rst_busy", 32'(tx_busy), 0);
    chk("rst_intr", 32'(UARTTXINTR), 0);
    chk("rst_empty", 32'(tx_fifo_empty), 1);
    chk("rst_full", 32'(tx_fifo_full), 0);
    chk("rst_count", 32'(tx_fifo_count), 0);
    chk("rst_ready", 32'(wr_ready), 1);
    PRESET = 1'b0;

    // Basic 8N1 frame at divisor 4, with latency and busy length.
    cfg_en = 1'b1;
    @(negedge PCLK);
    push(8'hA5, 1'b1);
    chk("lat_count", 32'(tx_fifo_count), 1);
    chk("lat_empty", 32'(tx_fifo_empty), 0);
    chk("lat_line_n", 32'(UARTTXD), 1);
    @(negedge PCLK);
    chk("lat_busy", 32'(tx_busy), 1);
    chk("lat_line_n1", 32'(UARTTXD), 1);
    chk("lat_popped", 32'(tx_fifo_count), 0);
    bc = 1;
    fork
      check_frame(1'b1, 1'b0, "basic");
      begin
        for (int i = 0; i < 50; i++) begin
          @(negedge PCLK);
          bc += int'(tx_busy);
        end
      end
    join
    chk("busy_len", 32'(bc), 40);
    chk("basic_idle_line", 32'(UARTTXD), 1);

    // Parity modes on 7-bit 0x55: even, odd, stick eps=1, stick eps=0.
    cfg_divisor = 16'd2; cfg_wlen = 2'd2; cfg_pen = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cfg_eps = eps_t[k]; cfg_sps = sps_t[k];
      push(8'h55, 1'b1);
      check_frame(1'b1, 1'b0, $sformatf("par%0d", k));
    end

    // Random formats including divisor 0, line control disturbed mid-frame.
    for (int k = 0; k < 8; k++) begin
      cfg_wlen = 2'($urandom_range(0, 3)); cfg_pen = 1'($urandom);
      cfg_eps = 1'($urandom); cfg_sps = 1'($urandom); cfg_stp2 = 1'($urandom);
      cfg_divisor = 16'($urandom_range(0, 5));
      push(8'($urandom), 1'b1);
      check_frame(1'b1, 1'b1, $sformatf("rnd%0d", k));
    end

    // Overflow while disabled, then 16 back-to-back frames at divisor 1.
    cfg_en = 1'b0; cfg_wlen = 2'd3; cfg_pen = 1'b0; cfg_stp2 = 1'b0; cfg_divisor = 16'd1;
    @(negedge PCLK);
    for (int i = 0; i < 17; i++) push(8'($urandom), i < 16);
    chk("ovf_count", 32'(tx_fifo_count), 16);
    chk("ovf_full", 32'(tx_fifo_full), 1);
    chk("ovf_ready", 32'(wr_ready), 0);
    cfg_en = 1'b1;
    for (int i = 0; i < 16; i++) check_frame(i == 0, 1'b0, $sformatf("b2b%0d", i));
    @(negedge PCLK);
    chk("b2b_empty", 32'(tx_fifo_empty), 1);
    chk("b2b_busy", 32'(tx_busy), 0);
    chk("b2b_line", 32'(UARTTXD), 1);

    // CTS gating: held word waits, deassert mid-frame only blocks the next.
    cfg_divisor = 16'd2; cfg_ctsen = 1'b1; nUARTCTS = 1'b1;
    push(8'($urandom), 1'b1);
    repeat (20) @(negedge PCLK);
    chk("cts_hold_line", 32'(UARTTXD), 1);
    chk("cts_hold_count", 32'(tx_fifo_count), 1);
    push(8'($urandom), 1'b1);
    chk("cts_count2", 32'(tx_fifo_count), 2);
    nUARTCTS = 1'b0;
    fork
      check_frame(1'b1, 1'b0, "cts_a");
      begin
        repeat (6) @(negedge PCLK);
        nUARTCTS = 1'b1;
      end
    join
    repeat (10) @(negedge PCLK);
    chk("cts_wait_line", 32'(UARTTXD), 1);
    chk("cts_wait_count", 32'(tx_fifo_count), 1);
    chk("cts_wait_busy", 32'(tx_busy), 0);
    nUARTCTS = 1'b0;
    check_frame(1'b1, 1'b0, "cts_b");

    // Interrupt threshold 2 with one-cycle lag; FIFO held by CTS.
    cfg_txlvl = 5'd2; nUARTCTS = 1'b1;
    repeat (2) @(negedge PCLK);
    chk("intr_empty", 32'(UARTTXINTR), 1);
    mc = 0;
    for (int i = 0; i < 4; i++) begin
      prev = mc;
      push(8'($urandom), 1'b1);
      mc++;
      chk($sformatf("intr_cnt%0d", mc), 32'(tx_fifo_count), 32'(mc));
      chk($sformatf("intr_lvl%0d", mc), 32'(UARTTXINTR), 32'(prev <= 2));
    end
    @(negedge PCLK);
    chk("intr_at4", 32'(UARTTXINTR), 0);
    // Push and pop on the same edge.
    r = 8'($urandom);
    nUARTCTS = 1'b0; wr_valid = 1'b1; wr_data = r;
    @(negedge PCLK);
    wr_valid = 1'b0; nUARTCTS = 1'b1;
    exp_q.push_back(r);
    chk("pp_count", 32'(tx_fifo_count), 4);
    chk("pp_busy", 32'(tx_busy), 1);
    check_frame(1'b1, 1'b0, "pp_frame");
    repeat (5) @(negedge PCLK);
    chk("pp_hold", 32'(tx_fifo_count), 4);
    cfg_ctsen = 1'b0;
    for (int i = 0; i < 4; i++) check_frame(i == 0, 1'b0, $sformatf("drain%0d", i));
    @(negedge PCLK);
    chk("drain_empty", 32'(tx_fifo_empty), 1);

    // Break mid-frame: line low while two frames drain underneath.
    cfg_divisor = 16'd4;
    push(8'($urandom), 1'b0);
    push(8'($urandom), 1'b0);
    repeat (6) @(negedge PCLK);
    cfg_brk = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge PCLK);
      chk($sformatf("brk_line%0d", i), 32'(UARTTXD), 0);
    end
    chk("brk_drain", 32'(tx_fifo_count), 0);
    cfg_brk = 1'b0;
    n = 0;
    while (tx_busy && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    @(negedge PCLK);
    chk("brk_release", 32'(UARTTXD), 1);
    chk("brk_busy", 32'(tx_busy), 0);

    // Reset in the middle of DATA with words still queued.
    push(8'h00, 1'b0);
    push(8'h00, 1'b0);
    push(8'h00, 1'b0);
    repeat (8) @(negedge PCLK);
    chk("pre_rst_busy", 32'(tx_busy), 1);
    PRESET = 1'b1;
    @(negedge PCLK);
    chk("mrst_line", 32'(UARTTXD), 1);
    chk("mrst_count", 32'(tx_fifo_count), 0);
    chk("mrst_busy", 32'(tx_busy), 0);
    chk("mrst_empty", 32'(tx_fifo_empty), 1);
    chk("mrst_intr", 32'(UARTTXINTR), 0);
    PRESET = 1'b0;
    repeat (30) @(negedge PCLK);
    chk("mrst_quiet_line", 32'(UARTTXD), 1);
    chk("mrst_quiet_busy", 32'(tx_busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
